// File: rtl/freertos_pio_pkg.sv
// Shared constants for the button PIO: register word addresses
// and the encodings of the captured-edge selector.
package freertos_pio_pkg;
   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_RSVD    = 2'd1;
   localparam logic [1:0] ADDR_IRQMASK = 2'd2;
   localparam logic [1:0] ADDR_EDGECAP = 2'd3;

   localparam int EDGE_RISE = 0;
   localparam int EDGE_FALL = 1;
   localparam int EDGE_ANY  = 2;
endpackage

// File: rtl/pio_debounce.sv
// One input bit: 2-flop synchronizer, then a counter that only lets
// a level through after DEBOUNCE_CYCLES consecutive differing samples.
module pio_debounce #(
   parameter int   DEBOUNCE_CYCLES = 50000,
   parameter logic IDLE            = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic stable
);
   localparam int             CW   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0]  TERM = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1  <= IDLE;
         sync2  <= IDLE;
         stable <= IDLE;
         cnt    <= '0;
      end else begin
         sync1 <= din;
         sync2 <= sync1;
         if (sync2 == stable) begin
            cnt <= '0;
         end else if (cnt == TERM) begin
            stable <= sync2;
            cnt    <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end
endmodule

// File: rtl/freertos_buttons_pio.sv
// Avalon-MM button/switch input port: debounced DATA, IRQMASK and
// W1C EDGECAP registers with a level interrupt.
module freertos_buttons_pio
   import freertos_pio_pkg::*;
#(
   parameter int               WIDTH           = 4,
   parameter int               DEBOUNCE_CYCLES = 50000,
   parameter int               EDGE_TYPE       = 1,
   parameter logic [WIDTH-1:0] IDLE_LEVEL      = {WIDTH{1'b1}}
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);
   logic [WIDTH-1:0] stable;
   logic [WIDTH-1:0] stable_d;
   logic [WIDTH-1:0] evt;
   logic [WIDTH-1:0] mask;
   logic [WIDTH-1:0] cap;
   logic [WIDTH-1:0] clr;
   logic             wr;
   logic             unused_wdata;

   for (genvar i = 0; i < WIDTH; i++) begin : g_db
      pio_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .IDLE            (IDLE_LEVEL[i])
      ) u_db (
         .clk    (clk),
         .reset  (reset),
         .din    (in_port[i]),
         .stable (stable[i])
      );
   end

   always_comb begin
      evt = '0;
      if (EDGE_TYPE == EDGE_RISE)
         evt = stable & ~stable_d;
      else if (EDGE_TYPE == EDGE_FALL)
         evt = ~stable & stable_d;
      else
         evt = stable ^ stable_d;
   end

   assign wr           = chipselect && !write_n;
   assign clr          = (wr && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;
   assign unused_wdata = ^writedata;

   // A new event in the same cycle as its W1C clear keeps the bit set.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stable_d <= IDLE_LEVEL;
         mask     <= '0;
         cap      <= '0;
      end else begin
         stable_d <= stable;
         cap      <= (cap & ~clr) | evt;
         if (wr && address == ADDR_IRQMASK)
            mask <= writedata[WIDTH-1:0];
      end
   end

   always_comb begin
      readdata = '0;
      unique case (address)
         ADDR_DATA:    readdata[WIDTH-1:0] = stable;
         ADDR_IRQMASK: readdata[WIDTH-1:0] = mask;
         ADDR_EDGECAP: readdata[WIDTH-1:0] = cap;
         default:      readdata = '0;
      endcase
   end

   assign irq = |(cap & mask);
endmodule

// File: tb/tb_freertos_buttons_pio.sv
// Directed bench for freertos_buttons_pio (WIDTH=4, 4-cycle debounce,
// falling-edge capture).
module tb_freertos_buttons_pio;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  address = 2'd0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [31:0] writedata = '0;
   logic [3:0]  in_port = 4'hF;
   logic [31:0] readdata;
   logic        irq;

   int checks = 0;
   int failures = 0;

   freertos_buttons_pio #(
      .WIDTH           (4),
      .DEBOUNCE_CYCLES (4),
      .EDGE_TYPE       (1),
      .IDLE_LEVEL      (4'hF)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .in_port    (in_port),
      .readdata   (readdata),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      address = a;
      #1;
      d = readdata;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic test_reset;
      logic [31:0] d;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      rd(2'd0, d); checks++;
      if (d !== 32'hF) begin failures++; $display("FAIL reset_data got=%h exp=%h", d, 32'hF); end
      rd(2'd1, d); checks++;
      if (d !== 32'h0) begin failures++; $display("FAIL reset_rsvd got=%h exp=0", d); end
      rd(2'd2, d); checks++;
      if (d !== 32'h0) begin failures++; $display("FAIL reset_mask got=%h exp=0", d); end
      rd(2'd3, d); checks++;
      if (d !== 32'h0) begin failures++; $display("FAIL reset_cap got=%h exp=0", d); end
      checks++;
      if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_regs;
      logic [31:0] d;
      wr(2'd2, 32'hFFFF_FFF1);
      rd(2'd2, d); checks++;
      if (d !== 32'h1) begin failures++; $display("FAIL mask_rw got=%h exp=1", d); end
      wr(2'd0, 32'h0);
      wr(2'd1, 32'hF);
      rd(2'd0, d); checks++;
      if (d !== 32'hF) begin failures++; $display("FAIL data_ro got=%h exp=f", d); end
      rd(2'd1, d); checks++;
      if (d !== 32'h0) begin failures++; $display("FAIL rsvd_ro got=%h exp=0", d); end
   endtask

   task automatic test_press;
      logic [31:0] d;
      @(negedge clk);
      in_port = 4'hE;
      repeat (5) @(negedge clk);
      rd(2'd0, d); checks++;
      if (d !== 32'hF) begin failures++; $display("FAIL press_early got=%h exp=f", d); end
      @(negedge clk);
      rd(2'd0, d); checks++;
      if (d !== 32'hE) begin failures++; $display("FAIL press_data got=%h exp=e", d); end
      rd(2'd3, d); checks++;
      if (d !== 32'h0) begin failures++; $display("FAIL press_cap_early got=%h exp=0", d); end
      @(negedge clk);
      rd(2'd3, d); checks++;
      if (d !== 32'h1) begin failures++; $display("FAIL press_cap got=%h exp=1", d); end
      checks++;
      if (irq !== 1'b1) begin failures++; $display("FAIL press_irq got=%b exp=1", irq); end
      in_port = 4'hF;
      repeat (10) @(negedge clk);
      rd(2'd0, d); checks++;
      if (d !== 32'hF) begin failures++; $display("FAIL release_data got=%h exp=f", d); end
      rd(2'd3, d); checks++;
      if (d !== 32'h1) begin failures++; $display("FAIL release_cap got=%h exp=1", d); end
   endtask

   task automatic test_glitch;
      logic [31:0] d;
      wr(2'd3, 32'hF);
      in_port = 4'hB;
      repeat (3) @(negedge clk);
      in_port = 4'hF;
      repeat (10) @(negedge clk);
      rd(2'd0, d); checks++;
      if (d !== 32'hF) begin failures++; $display("FAIL glitch_data got=%h exp=f", d); end
      rd(2'd3, d); checks++;
      if (d !== 32'h0) begin failures++; $display("FAIL glitch_cap got=%h exp=0", d); end
      checks++;
      if (irq !== 1'b0) begin failures++; $display("FAIL glitch_irq got=%b exp=0", irq); end
   endtask

   task automatic test_w1c;
      logic [31:0] d;
      in_port = 4'hC;
      repeat (10) @(negedge clk);
      in_port = 4'hF;
      repeat (10) @(negedge clk);
      rd(2'd3, d); checks++;
      if (d !== 32'h3) begin failures++; $display("FAIL w1c_setup got=%h exp=3", d); end
      wr(2'd3, 32'h1);
      rd(2'd3, d); checks++;
      if (d !== 32'h2) begin failures++; $display("FAIL w1c_clear got=%h exp=2", d); end
      checks++;
      if (irq !== 1'b0) begin failures++; $display("FAIL w1c_irq_off got=%b exp=0", irq); end
      wr(2'd2, 32'h2);
      checks++;
      if (irq !== 1'b1) begin failures++; $display("FAIL w1c_irq_on got=%b exp=1", irq); end
      wr(2'd3, 32'h2);
      checks++;
      if (irq !== 1'b0) begin failures++; $display("FAIL w1c_irq_clr got=%b exp=0", irq); end
   endtask

   task automatic test_collision;
      logic [31:0] d;
      @(negedge clk);
      in_port = 4'hE;
      repeat (6) @(negedge clk);
      address    = 2'd3;
      writedata  = 32'h1;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
      rd(2'd3, d); checks++;
      if (d !== 32'h1) begin failures++; $display("FAIL collision_cap got=%h exp=1", d); end
      in_port = 4'hF;
      repeat (10) @(negedge clk);
      wr(2'd3, 32'hF);
      rd(2'd3, d); checks++;
      if (d !== 32'h0) begin failures++; $display("FAIL collision_clr got=%h exp=0", d); end
   endtask

   task automatic test_reset_mid;
      logic [31:0] d;
      wr(2'd2, 32'hF);
      in_port = 4'hE;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      #1;
      rd(2'd0, d); checks++;
      if (d !== 32'hF) begin failures++; $display("FAIL rmid_data got=%h exp=f", d); end
      rd(2'd2, d); checks++;
      if (d !== 32'h0) begin failures++; $display("FAIL rmid_mask got=%h exp=0", d); end
      in_port = 4'hF;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      wr(2'd2, 32'hF);
      repeat (10) @(negedge clk);
      rd(2'd3, d); checks++;
      if (d !== 32'h0) begin failures++; $display("FAIL rmid_cap got=%h exp=0", d); end
      rd(2'd0, d); checks++;
      if (d !== 32'hF) begin failures++; $display("FAIL rmid_data2 got=%h exp=f", d); end
      checks++;
      if (irq !== 1'b0) begin failures++; $display("FAIL rmid_irq got=%b exp=0", irq); end
   endtask

   initial begin
      test_reset;
      test_regs;
      test_press;
      test_glitch;
      test_w1c;
      test_collision;
      test_reset_mid;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
